// File: rtl/nios_debug_scan_engine_pkg.sv
// Shared types and defaults for the Nios II debug scan engine.
package nios_dbg_pkg;

    localparam int DEF_DR_W = 38;
    localparam int DEF_IR_W = 2;

    // Encoding kept as plain constants so legacy code can compare against them.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        ARMED = ST_ARMED
    } scan_state_e;

    // Number of scan strobes asserted in one clock.
    function automatic logic [1:0] strobe_cnt(input logic a, input logic b, input logic c);
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

endpackage

// File: rtl/nios_debug_scan_engine_if.sv
// Command output bus of the scan engine: one word per valid/ready transfer.
interface nios_debug_scan_engine_if
    import nios_dbg_pkg::*;
#(
    parameter int DR_W = DEF_DR_W,
    parameter int IR_W = DEF_IR_W
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_data;
    logic            cmd_len_ok;

    modport master (output cmd_valid, output cmd_ir, output cmd_data, output cmd_len_ok,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_ir, input  cmd_data, input  cmd_len_ok,
                    output cmd_ready);
endinterface

// File: rtl/nios_debug_scan_engine_cmd_slot.sv
// Single-entry command output register with overrun detection.
module nios_debug_cmd_slot
    import nios_dbg_pkg::*;
#(
    parameter int DR_W = DEF_DR_W,
    parameter int IR_W = DEF_IR_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [DR_W-1:0]           ld_data,
    input  logic [IR_W-1:0]           ld_ir,
    input  logic                      ld_len_ok,
    input  logic                      clr_err,
    nios_debug_scan_engine_if.master  cmd,
    output logic                      overrun
);
    logic            valid_q, valid_d;
    logic [DR_W-1:0] data_q, data_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            len_ok_q, len_ok_d;
    logic            ovr_q, ovr_d;
    logic            blocked;

    // A pending word that is not being accepted this clock blocks any new load.
    assign blocked = valid_q & ~cmd.cmd_ready;

    // Load a new word, retire an accepted one, or drop the new word and flag overrun.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        ir_d     = ir_q;
        len_ok_d = len_ok_q;
        if (load && !blocked) begin
            valid_d  = 1'b1;
            data_d   = ld_data;
            ir_d     = ld_ir;
            len_ok_d = ld_len_ok;
        end else if (valid_q && cmd.cmd_ready) begin
            valid_d  = 1'b0;
        end
        // Set beats clear so an overrun in the clearing clock is not lost.
        ovr_d = (ovr_q & ~clr_err) | (load & blocked);
    end

    // Output register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            ir_q     <= '0;
            len_ok_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            ir_q     <= ir_d;
            len_ok_q <= len_ok_d;
            ovr_q    <= ovr_d;
        end
    end

    assign cmd.cmd_valid  = valid_q;
    assign cmd.cmd_data   = data_q;
    assign cmd.cmd_ir     = ir_q;
    assign cmd.cmd_len_ok = len_ok_q;
    assign overrun        = ovr_q;

endmodule

// File: rtl/nios_debug_scan_engine.sv
// Single-clock debug scan engine: capture, shift and update of a DR_W scan
// register driven by pre-synchronised strobes; updates become commands.
module nios_debug_scan_engine
    import nios_dbg_pkg::*;
#(
    parameter int DR_W = DEF_DR_W,
    parameter int IR_W = DEF_IR_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [IR_W-1:0]              ir_in,
    input  logic                         vs_cdr,
    input  logic                         vs_sdr,
    input  logic                         vs_udr,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic [(2**IR_W)*DR_W-1:0]    cap_data,
    nios_debug_scan_engine_if.master     cmd,
    output logic                         overrun,
    output logic                         proto_err,
    input  logic                         clr_err,
    output logic                         st_idle
);
    localparam int               CNT_W    = $clog2(DR_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_W + 1);

    scan_state_e     state_q, state_d;
    logic [DR_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IR_W-1:0] ir_lat_q, ir_lat_d;
    logic            perr_q, perr_d;
    logic            armed, do_cap, do_upd, do_shf;

    // Strobe priority cdr > udr > sdr; udr/sdr only act once armed by a capture.
    assign armed  = (state_q == ARMED);
    assign do_cap = vs_cdr;
    assign do_upd = vs_udr & ~vs_cdr & armed;
    assign do_shf = vs_sdr & ~vs_cdr & ~vs_udr & armed;

    // Scan register, shift counter, FSM and protocol-error next state.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        ir_lat_d = ir_lat_q;
        if (do_cap) begin
            sr_d     = cap_data[ir_in*DR_W +: DR_W];
            ir_lat_d = ir_in;
            cnt_d    = '0;
            state_d  = ARMED;
        end else if (do_upd) begin
            state_d  = IDLE;
        end else if (do_shf) begin
            sr_d = {tdi, sr_q[DR_W-1:1]};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
        perr_d = (perr_q & ~clr_err)
               | (strobe_cnt(vs_cdr, vs_sdr, vs_udr) > 2'd1)
               | (~armed & (vs_sdr | vs_udr));
    end

    // Engine state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            ir_lat_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            ir_lat_q <= ir_lat_d;
            perr_q   <= perr_d;
        end
    end

    nios_debug_cmd_slot #(.DR_W(DR_W), .IR_W(IR_W)) u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (do_upd),
        .ld_data   (sr_q),
        .ld_ir     (ir_lat_q),
        .ld_len_ok (cnt_q == CNT_FULL),
        .clr_err   (clr_err),
        .cmd       (cmd),
        .overrun   (overrun)
    );

    assign tdo       = sr_q[0];
    assign proto_err = perr_q;
    assign st_idle   = (state_q == IDLE) & ~cmd.cmd_valid;

endmodule
